matrix_commit_responder: RTL
============================

Name: matrix_commit_responder

Overview:
- Playfield matrix storage and the responder end of the piece-commit write interface.
- Accepts one 4x4 piece write at a board position and ORs it into the matrix, clipping cells outside the board.
- Then compacts the matrix: full rows are removed and the rows above drop down.
- Drives mm_is_ready high when idle. Exposes a row read port for collision checking and a lines-cleared report for scoring.

Parameters:
width_p, 16, board columns; row storage width
height_p, 32, board rows; row 0 is top, height_p-1 is bottom

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
mm_write_addr_i  in  point_t  piece origin; signed x (column) and y (row)
mm_write_data_i  in  shape_t ([3:0][3:0])  data[r][c] = cell at row y+r, column x+c
mm_write_v_i  in  1  write request, single-cycle pulse
mm_is_ready_o  out  1  high when idle and able to accept a write
rd_row_addr_i  in  $clog2(height_p)  row index for read port
rd_row_data_o  out  width_p  combinational contents of matrix[rd_row_addr_i]; bit i = column i
lines_v_o  out  1  one-cycle pulse when a commit completes
lines_cleared_o  out  3  number of rows removed by that commit (0..4)

Behaviour:
- Reset, asynchronous, any state:
  - all matrix rows 0; state IDLE
  - mm_is_ready_o=1; lines_v_o=0; lines_cleared_o=0
  - internal row counter, rd/wr pointers and line count 0
- mm_is_ready_o = (state==IDLE), decoded from the registered state.
- Accept: in cycle T, IDLE & mm_write_v_i -> register addr/data, go to MERGE. mm_is_ready_o=0 from T+1.
- mm_write_v_i outside IDLE is ignored; no queuing.
- MERGE (cycles T+1..T+4, r=0..3):
  - target row ty = y+r.
  - If 0<=ty<height_p: matrix[ty] |= placed bits, where column x+c gets data[r][c] if 0<=x+c<width_p.
  - Out-of-range cells are dropped silently.
  - Coordinate arithmetic is signed, one bit wider than the point_t field.
- COMPACT (height_p cycles): rd=wr=height_p-1, cnt=0. Each cycle:
  - if matrix[rd]==all-ones: cnt++, rd--
  - else: matrix[wr]<=matrix[rd], wr--, rd--
  - After processing rd==0: go to FILL if cnt>0, else IDLE.
  - Invariant wr>=rd, so rows are always read before they are overwritten.
- FILL (cnt cycles): matrix[wr]<=0, wr--; after cnt cycles go to IDLE.
- Completion, first IDLE cycle after commit:
  - lines_v_o=1 for one cycle; lines_cleared_o=cnt.
  - lines_cleared_o holds its value until the next completion.
- Busy window: mm_is_ready_o low for exactly 4+height_p+cnt cycles, T+1 through T+4+height_p+cnt.
- Line count: cnt is 3 bits and saturates at 7. A legal commit yields at most 4, since each commit clears every full row it creates.
- Read port: combinational in all states. During MERGE/COMPACT/FILL it returns intermediate contents; consumers read only while mm_is_ready_o=1.
- Edge cases:
  - Empty shape: full pass runs, matrix unchanged, lines_cleared_o=0.
  - Write with all cells out of bounds: same result.
  - Simultaneous mm_write_v_i on the completion cycle is accepted; that cycle is IDLE.
  - Reset mid-operation clears the matrix and aborts the commit; no lines_v_o pulse.

Decomposition:
- Package tetris holds point_t, shape_t and a new typedef row_t (logic [width_p-1:0] requires a package constant BOARD_W=16, BOARD_H=32). The module parameters default to these constants.
- Sub-module matrix_row_merge is combinational: inputs row_t, 4-bit shape row, signed x; output row_t with the clipped OR applied. It is instantiated once and used in MERGE.
- FSM, pointers and storage stay in the top module.

Test Plan:
- Reset -> every rd_row_data_o=0, mm_is_ready_o=1, lines_v_o=0. Assert reset mid-COMPACT -> matrix all 0, ready=1 next cycle, no lines_v_o pulse.
- Write x=3, y=10, data[0]=4'b0110, other rows 0 -> ready low for 36 cycles. Then row 10 = 16'h0030 (columns 4,5), lines_v_o pulse, lines_cleared_o=0.
- Four commits of an I-row (data[0]=4'b1111) at x=0,4,8 and then x=12, y=31 -> the last commit clears row 31. Result: lines_cleared_o=1, ready low 37 cycles, matrix all 0. Repeat with a cell preloaded at row 30 -> that cell appears in row 31.
- Fill columns 1..15 of rows 28..31, then commit a vertical I (data[r]=4'b0001) at x=0, y=28 -> lines_cleared_o=4, ready low 40 cycles, rows 28..31 = 0.
- Clipping: full shape 16'hFFFF at x=-2, y=-1 -> rows 0..2 = 16'h0003; no other rows touched.
- mm_write_v_i pulsed during MERGE with different data -> ignored; the final matrix reflects only the first write.

Source files
------------

// File: rtl/matrix_commit_responder_pkg.sv
// tetris: shared playfield types, board dimensions and commit FSM states
package tetris;
    localparam int BOARD_W = 16;
    localparam int BOARD_H = 32;
    typedef struct packed {
        logic signed [7:0] x;
        logic signed [7:0] y;
    } point_t;
    typedef logic [3:0][3:0] shape_t;
    typedef logic [BOARD_W-1:0] row_t;
    typedef enum logic [1:0] {IDLE, MERGE, COMPACT, FILL} state_t;
endpackage

// File: rtl/matrix_commit_responder_if.sv
// matrix_commit_responder_if: piece-commit write channel between mover and matrix
interface matrix_commit_responder_if;
    import tetris::*;
    point_t mm_write_addr;
    shape_t mm_write_data;
    logic mm_write_v;
    logic mm_is_ready;
    modport master(output mm_write_addr, mm_write_data, mm_write_v, input mm_is_ready);
    modport slave(input mm_write_addr, mm_write_data, mm_write_v, output mm_is_ready);
endinterface

// File: rtl/matrix_commit_responder_row_merge.sv
// matrix_row_merge: ORs one 4-cell shape row into a board row at signed column x, clipping off-board cells
module matrix_row_merge #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] row_i,
    input  logic [3:0]         bits_i,
    input  logic signed [8:0]  x_i,
    output logic [width_p-1:0] row_o
);
    for (genvar j = 0; j < width_p; j++) begin : g_col
        logic signed [9:0] off;
        assign off = 10'(j) - 10'(x_i);
        assign row_o[j] = row_i[j] | (!off[9] && off < 10'sd4 && bits_i[off[1:0]]);
    end
endmodule

// File: rtl/matrix_commit_responder.sv
// matrix_commit_responder: playfield storage that merges committed pieces and compacts full rows
module matrix_commit_responder
    import tetris::*;
#(
    parameter int width_p = BOARD_W,
    parameter int height_p = BOARD_H
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    matrix_commit_responder_if.slave    mm,
    input  logic [$clog2(height_p)-1:0] rd_row_addr_i,
    output logic [width_p-1:0]          rd_row_data_o,
    output logic                        lines_v_o,
    output logic [2:0]                  lines_cleared_o
);
    localparam int aw = $clog2(height_p);
    localparam logic [aw-1:0] last = aw'(height_p - 1);

    logic [width_p-1:0] matrix [height_p];
    state_t state, state_n;
    point_t addr;
    shape_t data;
    logic [1:0] row_cnt;
    logic [aw-1:0] rd, wr;
    logic [2:0] cnt, cnt_n;
    logic signed [8:0] tx, ty;
    logic [width_p-1:0] merged;
    logic full, done;

    assign tx = {addr.x[7], addr.x};
    assign ty = {addr.y[7], addr.y} + {7'd0, row_cnt};
    assign full = &matrix[rd];
    assign rd_row_data_o = matrix[rd_row_addr_i];
    assign mm.mm_is_ready = state == IDLE;

    matrix_row_merge #(.width_p(width_p)) u_merge (
        .row_i  (matrix[ty[aw-1:0]]),
        .bits_i (data[row_cnt]),
        .x_i    (tx),
        .row_o  (merged)
    );

    always_comb begin
        cnt_n = (state == COMPACT && full && cnt != 3'd7) ? cnt + 3'd1 : cnt;
        state_n = state == IDLE ? (mm.mm_write_v ? MERGE : IDLE)
                : state == MERGE ? (row_cnt == 2'd3 ? COMPACT : MERGE)
                : state == COMPACT ? (rd != '0 ? COMPACT : cnt_n != '0 ? FILL : IDLE)
                : (wr != '0 ? FILL : IDLE);
        done = state != IDLE && state_n == IDLE;
    end

    always_ff @(posedge clk_i or posedge reset_i)
        state <= reset_i ? IDLE : state_n;

    // Compaction walks bottom-up; wr never passes rd, so each row is read before it is overwritten
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < height_p; i++) matrix[i] <= '0;
            addr <= '0;
            data <= '0;
            row_cnt <= '0;
            rd <= '0;
            wr <= '0;
            cnt <= '0;
            lines_v_o <= 1'b0;
            lines_cleared_o <= '0;
        end else begin
            lines_v_o <= done;
            if (done) lines_cleared_o <= cnt_n;
            cnt <= cnt_n;
            if (state == IDLE && mm.mm_write_v) begin
                addr <= mm.mm_write_addr;
                data <= mm.mm_write_data;
                row_cnt <= '0;
                cnt <= '0;
            end
            if (state == MERGE) begin
                row_cnt <= row_cnt + 2'd1;
                rd <= last;
                wr <= last;
                if (!ty[8] && ty < 9'(height_p)) matrix[ty[aw-1:0]] <= merged;
            end
            if (state == COMPACT) begin
                rd <= rd - aw'(1);
                if (!full) begin
                    matrix[wr] <= matrix[rd];
                    wr <= wr - aw'(1);
                end
            end
            if (state == FILL) begin
                matrix[wr] <= '0;
                wr <= wr - aw'(1);
            end
        end
    end
endmodule
